// File: rtl/apa_sample_sequencer.sv
// Sample sequencer for an adaptive-filter datapath: pulls one noisy/desired pair per
// sample, fires the filter, waits (bounded) for its result and hands it downstream.
module apa_sample_sequencer #(
    parameter int DATA_W  = 16,
    parameter int CNT_W   = 10,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    input  logic [CNT_W-1:0]  cfg_block_len,
    input  logic [DATA_W-1:0] noisy_in,
    input  logic [DATA_W-1:0] desired_in,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] filt_noisy,
    output logic [DATA_W-1:0] filt_desired,
    output logic              filt_start,
    input  logic              filt_done,
    input  logic [DATA_W-1:0] filt_out,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              block_done,
    output logic              timeout_err,
    output logic [CNT_W-1:0]  sample_cnt
);

    localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_START, S_WAIT, S_OUTPUT, S_DONE
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] block_len;
    logic [TMR_W-1:0] timer;
    logic             block_start;
    logic             last_sample;

    assign block_start = run && (cfg_block_len != '0);
    assign last_sample = (sample_cnt == block_len - CNT_W'(1));

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // NOTE: every output is given a default before the case, so no path leaves one
    // unassigned and no latch is inferred.
    always_comb begin
        state_nxt  = state;
        in_ready   = 1'b0;
        filt_start = 1'b0;
        out_valid  = 1'b0;
        block_done = 1'b0;
        busy       = (state != S_IDLE);
        case (state)
            S_IDLE:   if (block_start) state_nxt = S_LOAD;
            S_LOAD: begin
                // Dropping run aborts the block, so no sample is accepted that cycle.
                in_ready = run;
                if (!run)          state_nxt = S_IDLE;
                else if (in_valid) state_nxt = S_START;
            end
            S_START: begin
                filt_start = 1'b1;
                state_nxt  = S_WAIT;
            end
            S_WAIT:   if (filt_done || timer == TMR_LAST) state_nxt = S_OUTPUT;
            S_OUTPUT: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = last_sample ? S_DONE : S_LOAD;
            end
            S_DONE: begin
                block_done = 1'b1;
                state_nxt  = S_IDLE;
            end
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            block_len    <= '0;
            timer        <= '0;
            sample_cnt   <= '0;
            timeout_err  <= 1'b0;
            filt_noisy   <= '0;
            filt_desired <= '0;
            out_data     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (block_start) begin
                        block_len   <= cfg_block_len;
                        sample_cnt  <= '0;
                        timeout_err <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (!run) begin
                        sample_cnt <= '0;
                    end else if (in_valid) begin
                        filt_noisy   <= noisy_in;
                        filt_desired <= desired_in;
                    end
                end
                S_START: timer <= '0;
                S_WAIT: begin
                    timer <= timer + 1'b1;
                    // A result arriving on the last allowed cycle still wins over bypass.
                    if (filt_done) begin
                        out_data <= filt_out;
                    end else if (timer == TMR_LAST) begin
                        out_data    <= filt_noisy;
                        timeout_err <= 1'b1;
                    end
                end
                S_OUTPUT: if (out_ready && !last_sample) sample_cnt <= sample_cnt + 1'b1;
                S_DONE:   sample_cnt <= '0;
                default:  ;
            endcase
        end
    end

endmodule

// File: doc/apa_sample_sequencer.md
APA_SAMPLE_SEQUENCER -- requirements
Module: apa_sample_sequencer

Interface
REQ-001 SHALL have parameter DATA_W, default 16, sample width.
REQ-002 SHALL have parameter CNT_W, default 10, block length and sample counter width.
REQ-003 SHALL have parameter TIMEOUT, default 16, maximum cycles spent waiting for filt_done.
REQ-004 clk  in  1  single clock; all logic on its rising edge.
REQ-005 reset  in  1  synchronous, active-low reset.
REQ-006 run  in  1  level; high requests a block of samples.
REQ-007 cfg_block_len  in  CNT_W  samples per block, sampled on block start.
REQ-008 noisy_in, desired_in  in  DATA_W each  input sample pair.
REQ-009 in_valid  in  1 / in_ready  out  1  input handshake.
REQ-010 filt_noisy, filt_desired  out  DATA_W each  registered operands to the adaptive filter.
REQ-011 filt_start  out  1 / filt_done  in  1 / filt_out  in  DATA_W  filter sequencing and result.
REQ-012 out_data  out  DATA_W / out_valid  out  1 / out_ready  in  1  output handshake.
REQ-013 busy, block_done, timeout_err  out  1 each; sample_cnt  out  CNT_W.

Function
REQ-014 SHALL implement FSM states IDLE, LOAD, START, WAIT, OUTPUT, DONE.
REQ-015 IDLE: run=1 and cfg_block_len!=0 -> latch block length, go LOAD; cfg_block_len==0 -> stay IDLE, busy stays 0.
REQ-016 busy SHALL be 1 in every state except IDLE.
REQ-017 LOAD: in_ready=1 (only here); on in_valid&in_ready -> register noisy_in/desired_in onto filt_noisy/filt_desired, go START.
REQ-018 LOAD with run=0 -> IDLE next cycle, sample_cnt cleared, no block_done; run is ignored in all other non-IDLE states.
REQ-019 START: filt_start=1 for exactly one cycle, timer cleared, go WAIT; filt_noisy/filt_desired SHALL be held stable from START until the next LOAD capture.
REQ-020 WAIT: filt_done=1 -> out_data<=filt_out, go OUTPUT.
REQ-021 WAIT: timer reaching TIMEOUT-1 without filt_done -> out_data<=filt_noisy (bypass), timeout_err<=1, go OUTPUT.
REQ-022 filt_done and timeout in the same cycle -> filt_done wins, timeout_err unchanged.
REQ-023 filt_done outside WAIT SHALL be ignored.
REQ-024 OUTPUT: out_valid=1 with out_data stable until out_ready=1; on the handshake cycle, if sample_cnt==latched_len-1 go DONE, else sample_cnt+1 and go LOAD.
REQ-025 DONE: block_done=1 for one cycle, sample_cnt<=0, go IDLE.
REQ-026 A new block can start no earlier than the cycle after DONE; cfg_block_len changes mid-block SHALL have no effect.
REQ-027 timeout_err SHALL be sticky and clear only on reset or on a block start from IDLE.
REQ-028 Minimum per-sample latency, input handshake to out_valid, SHALL be 3 cycles with filt_done returned the cycle after filt_start.

Reset
REQ-029 reset=0 at a rising edge SHALL force IDLE from any state, including mid-block.
REQ-030 reset SHALL clear every output to 0: in_ready, filt_start, out_valid, busy, block_done, timeout_err, sample_cnt, filt_noisy, filt_desired, out_data.
REQ-031 On the first edge with reset=1 the block SHALL evaluate IDLE transitions normally.

Verification
REQ-032 cfg_block_len=3, run=1, in_valid always high, filt_done 1 cycle after filt_start, out_ready=1 -> 3 outputs equal to filt_out, then one block_done pulse, sample_cnt back to 0, busy=0.
REQ-033 filt_done never asserted, noisy_in=16'd1234 -> out_data=1234 after TIMEOUT WAIT cycles (16 at default), timeout_err=1, stays 1 into the next sample.
REQ-034 out_ready held low for 5 cycles in OUTPUT -> out_valid and out_data stable for all 5 cycles; in_ready=0 and no filt_start during the stall.
REQ-035 Drop run while in LOAD after 1 of 4 samples -> IDLE next cycle, no block_done, sample_cnt=0; cfg_block_len=0 with run=1 -> busy stays 0.
REQ-036 reset=0 in WAIT mid-block -> all outputs 0 the next cycle; after release, a block of 2 completes normally.
REQ-037 filt_done coincident with the final timeout cycle -> out_data=filt_out, timeout_err stays 0.
